// File: rtl/sensor_protocol_pkg.sv
// Shared definitions for the sensor command link: request codes, error codes,
// dispatcher state encoding and a small classification helper.
package sensor_protocol_pkg;

   // Request codes understood by the sensor decoder
   localparam logic [7:0] REQ_CODE_00 = 8'h00;
   localparam logic [7:0] REQ_CODE_01 = 8'h01;
   localparam logic [7:0] REQ_CODE_02 = 8'h02;
   localparam logic [7:0] REQ_CODE_03 = 8'h03;
   localparam logic [7:0] REQ_CODE_04 = 8'h04;
   localparam logic [7:0] REQ_CODE_05 = 8'h05;
   localparam logic [7:0] REQ_CODE_06 = 8'h06;
   localparam logic [7:0] REQ_CODE_07 = 8'h07;
   localparam logic [7:0] REQ_CODE_08 = 8'h08;

   // Codes 07/08 stop a running measurement rather than start a new one
   localparam logic [7:0] REQ_STOP_A = REQ_CODE_07;
   localparam logic [7:0] REQ_STOP_B = REQ_CODE_08;

   // Error responses; chosen well away from the decoder status bytes 8'h10/8'h11
   localparam logic [7:0] ERR_BAD_ADDR = 8'hE0;
   localparam logic [7:0] ERR_TIMEOUT  = 8'hE1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GET_CMD = 3'd1,
      ISSUE   = 3'd2,
      WAIT    = 3'd3,
      RESPOND = 3'd4
   } dispatch_state_t;

   function automatic logic is_stop_code(input logic [7:0] code);
      return (code == REQ_STOP_A) || (code == REQ_STOP_B);
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating cycle counter with a terminal-count flag, used for the inter-byte
// gap and the decoder reply deadline. Never wraps once it reaches the limit.
module timeout_counter #(
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic terminal
);

   localparam int RAW_W = $clog2(TIMEOUT_CYCLES);
   localparam int CNT_W = (RAW_W > 23) ? RAW_W : 23;
   localparam logic [CNT_W-1:0] TERMINAL_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Clear has priority; counting stops at the terminal value
   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = '0;
      end else if (count_en && (count_reg != TERMINAL_COUNT)) begin
         count_next = count_reg + 1'b1;
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign terminal = (count_reg == TERMINAL_COUNT);

endmodule

// File: rtl/sensor_command_dispatcher.sv
// Assembles 2-byte command frames (address, request) from the UART byte stream,
// starts the sensor decoder, waits for its reply with a deadline and presents a
// 2-byte response with valid/ready handshake to the transmit path.
module sensor_command_dispatcher
   import sensor_protocol_pkg::*;
#(
   parameter int NUM_DEVICES    = 32,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   decoder_finished,
   input  logic [7:0]             decoder_data,
   output logic                   enable,
   output logic [NUM_DEVICES-1:0] device_selector,
   output logic [7:0]             request,
   output logic                   resp_valid,
   output logic [7:0]             resp_code,
   output logic [7:0]             resp_data,
   input  logic                   resp_ready,
   output logic                   busy
);

   localparam logic [8:0] NUM_DEVICES_W = 9'(NUM_DEVICES);

   dispatch_state_t state_reg, state_next;
   logic [7:0] addr_reg, addr_next;
   logic [7:0] cmd_reg, cmd_next;
   logic       stop_armed_reg, stop_armed_next;
   logic [7:0] stop_addr_reg, stop_addr_next;
   logic       enable_reg, enable_next;
   logic [NUM_DEVICES-1:0] selector_reg, selector_next;
   logic [7:0] request_reg, request_next;
   logic       resp_valid_reg, resp_valid_next;
   logic [7:0] resp_code_reg, resp_code_next;
   logic [7:0] resp_data_reg, resp_data_next;
   logic       cnt_clear, cnt_en, cnt_terminal;
   logic [NUM_DEVICES-1:0] addr_onehot;

   // One-hot decode of the latched address
   for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_select
      assign addr_onehot[gi] = (addr_reg == 8'(gi));
   end

   timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .terminal (cnt_terminal)
   );

   // Next-state and next-output logic; registered outputs hold by default
   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      cmd_next        = cmd_reg;
      stop_armed_next = stop_armed_reg;
      stop_addr_next  = stop_addr_reg;
      enable_next     = 1'b0;
      selector_next   = selector_reg;
      request_next    = request_reg;
      resp_valid_next = resp_valid_reg;
      resp_code_next  = resp_code_reg;
      resp_data_next  = resp_data_reg;
      cnt_clear       = 1'b0;
      cnt_en          = 1'b0;
      unique case (state_reg)
         IDLE: begin
            cnt_clear = 1'b1;
            if (rx_valid) begin
               addr_next  = rx_data;
               state_next = GET_CMD;
            end
         end
         GET_CMD: begin
            cnt_en = 1'b1;
            if (rx_valid) begin
               cmd_next = rx_data;
               if ({1'b0, addr_reg} >= NUM_DEVICES_W) begin
                  resp_valid_next = 1'b1;
                  resp_code_next  = ERR_BAD_ADDR;
                  resp_data_next  = addr_reg;
                  state_next      = RESPOND;
               end else begin
                  state_next = ISSUE;
               end
            end else if (cnt_terminal) begin
               // Half a frame and then silence: drop it without answering
               state_next = IDLE;
            end
         end
         ISSUE: begin
            cnt_clear       = 1'b1;
            enable_next     = 1'b1;
            selector_next   = addr_onehot;
            request_next    = cmd_reg;
            stop_armed_next = 1'b0;
            state_next      = WAIT;
         end
         WAIT: begin
            cnt_en = 1'b1;
            // A reply arriving on the deadline cycle still counts as a reply
            if (decoder_finished) begin
               resp_valid_next = 1'b1;
               resp_code_next  = cmd_reg;
               resp_data_next  = decoder_data;
               state_next      = RESPOND;
            end else if (cnt_terminal) begin
               resp_valid_next = 1'b1;
               resp_code_next  = ERR_TIMEOUT;
               resp_data_next  = 8'h00;
               state_next      = RESPOND;
            end else if (rx_valid) begin
               // Track frames while waiting; only a stop frame for the busy device acts
               if (!stop_armed_reg) begin
                  stop_armed_next = 1'b1;
                  stop_addr_next  = rx_data;
               end else begin
                  stop_armed_next = 1'b0;
                  if ((stop_addr_reg == addr_reg) && is_stop_code(rx_data)) begin
                     request_next = rx_data;
                  end
               end
            end
         end
         RESPOND: begin
            if (resp_valid_reg && resp_ready) begin
               resp_valid_next = 1'b0;
               selector_next   = '0;
               request_next    = '0;
               state_next      = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset overrides any frame or wait in progress
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         cmd_reg        <= '0;
         stop_armed_reg <= 1'b0;
         stop_addr_reg  <= '0;
         enable_reg     <= 1'b0;
         selector_reg   <= '0;
         request_reg    <= '0;
         resp_valid_reg <= 1'b0;
         resp_code_reg  <= '0;
         resp_data_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         cmd_reg        <= cmd_next;
         stop_armed_reg <= stop_armed_next;
         stop_addr_reg  <= stop_addr_next;
         enable_reg     <= enable_next;
         selector_reg   <= selector_next;
         request_reg    <= request_next;
         resp_valid_reg <= resp_valid_next;
         resp_code_reg  <= resp_code_next;
         resp_data_reg  <= resp_data_next;
      end
   end

   assign enable          = enable_reg;
   assign device_selector = selector_reg;
   assign request         = request_reg;
   assign resp_valid      = resp_valid_reg;
   assign resp_code       = resp_code_reg;
   assign resp_data       = resp_data_reg;
   assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_sensor_command_dispatcher.sv
// Bench for sensor_command_dispatcher: table of command frames plus hand-built
// sequences for timeouts, stop frames, back-pressure and reset during a wait.
module tb_sensor_command_dispatcher;

   localparam int NUM_DEVICES    = 32;
   localparam int TIMEOUT_CYCLES = 100;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   rx_valid = 1'b0;
   logic [7:0]             rx_data = 8'h00;
   logic                   decoder_finished = 1'b0;
   logic [7:0]             decoder_data = 8'h00;
   logic                   enable;
   logic [NUM_DEVICES-1:0] device_selector;
   logic [7:0]             request;
   logic                   resp_valid;
   logic [7:0]             resp_code;
   logic [7:0]             resp_data;
   logic                   resp_ready = 1'b1;
   logic                   busy;

   always #5 clock = ~clock;

   sensor_command_dispatcher #(
      .NUM_DEVICES    (NUM_DEVICES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .decoder_finished (decoder_finished),
      .decoder_data     (decoder_data),
      .enable           (enable),
      .device_selector  (device_selector),
      .request          (request),
      .resp_valid       (resp_valid),
      .resp_code        (resp_code),
      .resp_data        (resp_data),
      .resp_ready       (resp_ready),
      .busy             (busy)
   );

   typedef struct packed {
      logic [7:0] code;
      logic [7:0] data;
   } resp_t;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  cmd;
      int          fin_delay;   // -1: decoder never answers
      logic [7:0]  fin_data;
      bit          exp_en;
      logic [31:0] exp_sel;
      logic [7:0]  exp_code;
      logic [7:0]  exp_data;
   } vec_t;

   resp_t exp_q[$];
   int    n_checks      = 0;
   int    n_pass        = 0;
   int    cyc           = 0;
   int    enable_count  = 0;
   int    n_transfers   = 0;
   int    rise_cyc      = -1;
   int    last_byte_cyc = 0;
   int    fin_cyc       = 0;
   logic  resp_valid_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: counts enable pulses, timestamps response rise, scores transfers
   always @(negedge clock) begin
      resp_t e;
      if (reset) begin
         if (enable) enable_count++;
         if (resp_valid && !resp_valid_prev) rise_cyc = cyc;
         if (resp_valid && resp_ready) begin
            $display("resp transfer code=%h data=%h at cycle %0d", resp_code, resp_data, cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'(resp_code), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("resp_code", 32'(resp_code), 32'(e.code));
               check("resp_data", 32'(resp_data), 32'(e.data));
            end
            n_transfers++;
         end
      end
      resp_valid_prev = resp_valid;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clock); #1;
      rx_valid = 1'b1;
      rx_data = b;
      last_byte_cyc = cyc;
      @(posedge clock); #1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic pulse_finish(input logic [7:0] d);
      @(posedge clock); #1;
      decoder_finished = 1'b1;
      decoder_data = d;
      fin_cyc = cyc;
      @(posedge clock); #1;
      decoder_finished = 1'b0;
   endtask

   task automatic wait_enable(input int max_cycles, output bit ok, output int at_cyc);
      ok = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clock);
         if (enable) begin
            ok = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_transfer(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clock);
         if (resp_valid && resp_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic run_vec(input vec_t v);
      int en0;
      int en_cyc;
      bit ok;
      en0 = enable_count;
      en_cyc = 0;
      send_byte(v.addr);
      send_byte(v.cmd);
      exp_q.push_back('{code: v.exp_code, data: v.exp_data});
      if (v.exp_en) begin
         wait_enable(10, ok, en_cyc);
         check("enable_seen", 32'(ok), 32'd1);
         check("enable_latency", 32'(en_cyc - last_byte_cyc), 32'd2);
         check("device_selector", device_selector, v.exp_sel);
         check("request", 32'(request), 32'(v.cmd));
      end
      if (v.fin_delay >= 0) begin
         repeat (v.fin_delay) @(posedge clock);
         pulse_finish(v.fin_data);
      end
      wait_transfer(TIMEOUT_CYCLES * 3, ok);
      check("transfer_seen", 32'(ok), 32'd1);
      @(negedge clock);
      check("busy_after", 32'(busy), 32'd0);
      check("selector_after", device_selector, 32'd0);
      check("request_after", 32'(request), 32'd0);
      check("enable_pulses", 32'(enable_count - en0), 32'(v.exp_en));
      if (v.fin_delay >= 0)
         check("finish_latency", 32'(rise_cyc - fin_cyc), 32'd1);
      else if (v.exp_code == 8'hE1)
         check("timeout_latency", 32'(rise_cyc - en_cyc), 32'(TIMEOUT_CYCLES));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      bit   ok;
      int   en0;
      int   tr0;
      int   en_cyc;

      vecs[0] = '{8'h00, 8'h01, 40, 8'h19, 1'b1, 32'h0000_0001, 8'h01, 8'h19};
      vecs[1] = '{8'h25, 8'h03, -1, 8'h00, 1'b0, 32'h0000_0000, 8'hE0, 8'h25};
      vecs[2] = '{8'h00, 8'h02, -1, 8'h00, 1'b1, 32'h0000_0001, 8'hE1, 8'h00};
      vecs[3] = '{8'h1F, 8'h04,  3, 8'h11, 1'b1, 32'h8000_0000, 8'h04, 8'h11};
      vecs[4] = '{8'h20, 8'h08, -1, 8'h00, 1'b0, 32'h0000_0000, 8'hE0, 8'h20};
      vecs[5] = '{8'h05, 8'h00,  0, 8'h10, 1'b1, 32'h0000_0020, 8'h00, 8'h10};
      vecs[6] = '{8'h0A, 8'h06,  1, 8'h00, 1'b1, 32'h0000_0400, 8'h06, 8'h00};

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_enable", 32'(enable), 32'd0);
      check("rst_selector", device_selector, 32'd0);
      check("rst_request", 32'(request), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_code", 32'(resp_code), 32'd0);
      check("rst_resp_data", 32'(resp_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;

      // Table-driven frames
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Half frame then silence: back to IDLE with no response
      tr0 = n_transfers;
      send_byte(8'h00);
      repeat (97) @(posedge clock);
      @(negedge clock);
      check("gap_still_busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("gap_idle", 32'(busy), 32'd0);
      check("gap_no_resp", 32'(resp_valid), 32'd0);
      check("gap_no_transfer", 32'(n_transfers - tr0), 32'd0);
      run_vec('{8'h00, 8'h03, 5, 8'h10, 1'b1, 32'h0000_0001, 8'h03, 8'h10});

      // Stop frame during WAIT updates request without a new enable
      en0 = enable_count;
      send_byte(8'h00);
      send_byte(8'h05);
      exp_q.push_back('{code: 8'h05, data: 8'h1A});
      wait_enable(10, ok, en_cyc);
      check("stop_enable_seen", 32'(ok), 32'd1);
      check("stop_request_initial", 32'(request), 32'h05);
      send_byte(8'h01);
      send_byte(8'h07);
      @(negedge clock);
      check("stop_other_addr_ignored", 32'(request), 32'h05);
      send_byte(8'h00);
      send_byte(8'h07);
      @(negedge clock);
      check("stop_request_updated", 32'(request), 32'h07);
      check("stop_selector_kept", device_selector, 32'h0000_0001);
      check("stop_no_response_yet", 32'(resp_valid), 32'd0);
      pulse_finish(8'h1A);
      wait_transfer(10, ok);
      check("stop_transfer_seen", 32'(ok), 32'd1);
      check("stop_single_enable", 32'(enable_count - en0), 32'd1);

      // Back-pressure: response held stable while resp_ready is low
      resp_ready = 1'b0;
      tr0 = n_transfers;
      send_byte(8'h02);
      send_byte(8'h06);
      exp_q.push_back('{code: 8'h06, data: 8'h44});
      wait_enable(10, ok, en_cyc);
      check("hold_enable_seen", 32'(ok), 32'd1);
      pulse_finish(8'h44);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_code", 32'(resp_code), 32'h06);
         check("hold_data", 32'(resp_data), 32'h44);
      end
      check("hold_no_transfer", 32'(n_transfers - tr0), 32'd0);
      @(posedge clock); #1;
      resp_ready = 1'b1;
      wait_transfer(5, ok);
      check("hold_transfer_seen", 32'(ok), 32'd1);
      @(negedge clock);
      check("hold_busy_after", 32'(busy), 32'd0);

      // Reset asserted while waiting on the decoder
      send_byte(8'h03);
      send_byte(8'h01);
      wait_enable(10, ok, en_cyc);
      check("rstwait_enable_seen", 32'(ok), 32'd1);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rstwait_enable", 32'(enable), 32'd0);
      check("rstwait_selector", device_selector, 32'd0);
      check("rstwait_request", 32'(request), 32'd0);
      check("rstwait_resp_valid", 32'(resp_valid), 32'd0);
      check("rstwait_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      run_vec('{8'h07, 8'h02, 2, 8'h11, 1'b1, 32'h0000_0080, 8'h02, 8'h11});

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
